// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: a WIDTH-bit operation is processed CHUNK bits per clock.
// Define SEQ_CHUNK_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic [CHUNK:0]   chunkSum;
    logic [WIDTH-1:0] resShift;

    assign chunkSum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    // New chunk enters at the top; after NCHUNK shifts the full sum is right-aligned.
    assign resShift = (res_q >> CHUNK) | (WIDTH'(chunkSum[CHUNK-1:0]) << (WIDTH - CHUNK));

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    logic carryIntoMsb;
    assign carryIntoMsb = chunkSum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        s_d     = s_q;
        co_d    = co_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = ci ^ sub;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                res_d   = resShift;
                carry_d = chunkSum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    s_d     = resShift;
                    co_d    = chunkSum[CHUNK];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                    ovf_d   = carryIntoMsb ^ chunkSum[CHUNK];
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            s_q     <= s_d;
            co_q    <= co_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign co        = co_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=8, CHUNK=2); checks ovf when SEQ_CHUNK_ADDER_OVF_EN is defined.
module tb_seq_chunk_adder;

    localparam int WIDTH  = 8;
    localparam int CHUNK  = 2;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] s;
    logic       co;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic       ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, returns {ovf, co, s}.
    function automatic logic [9:0] refModel(input logic [7:0] x, input logic [7:0] y,
                                            input logic c, input logic sb);
        logic [31:0] full;
        int          sres;
        logic        carry;
        logic        v;
        if (sb) begin
            full  = 32'(int'(x) - int'(y) - int'(c));
            carry = (int'(x) >= int'(y) + int'(c));
            sres  = int'($signed(x)) - int'($signed(y)) - int'(c);
        end else begin
            full  = 32'(int'(x) + int'(y) + int'(c));
            carry = (full > 32'd255);
            sres  = int'($signed(x)) + int'($signed(y)) + int'(c);
        end
        v = (sres > 127) || (sres < -128);
        return {v, carry, full[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one operation and waits until the result is presented.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                                 input logic c, input logic sb);
        logic onTime;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = x; b = y; ci = c; sub = sb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        for (int k = 0; k < NCHUNK; k++) begin
            check("out_valid_early", 32'(out_valid), 32'd0);
            tick();
        end
        onTime = out_valid;
        check("latency", 32'(onTime), 32'd1);
        for (int w = 0; w < 32 && !out_valid; w++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] x, input logic [7:0] y,
                               input logic c, input logic sb);
        logic [9:0] e;
        e = refModel(x, y, c, sb);
        check({tag, "_s"}, 32'(s), 32'(e[7:0]));
        check({tag, "_co"}, 32'(co), 32'(e[8]));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(e[9]));
`endif
    endtask

    task automatic finishOp();
        tick();
        check("back_to_idle_valid", 32'(out_valid), 32'd0);
        check("back_to_idle_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [9:0] e;
        logic [7:0] bx, by;
        logic       bc, bs;
        logic [9:0] expQ[$];
        int         accT[$];
        int         nAcc, nRes;
        logic       acceptNow;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        check("wrap_s", 32'(s), 32'h00);
        check("wrap_co", 32'(co), 32'd1);
        finishOp();

        applyStimulus(8'h05, 8'h07, 1'b0, 1'b1);
        check("sub_borrow_s", 32'(s), 32'hFE);
        check("sub_borrow_co", 32'(co), 32'd0);
        finishOp();

        applyStimulus(8'h07, 8'h05, 1'b1, 1'b1);
        check("sub_bin_s", 32'(s), 32'h01);
        check("sub_bin_co", 32'(co), 32'd1);
        finishOp();

        // Consumer stalls while new operands are already waiting
        out_ready = 1'b0;
        applyStimulus(8'h3C, 8'h4B, 1'b1, 1'b0);
        checkOutput("stall_first", 8'h3C, 8'h4B, 1'b1, 1'b0);
        e = refModel(8'h3C, 8'h4B, 1'b1, 1'b0);
        a = 8'hA5; b = 8'h11; ci = 1'b0; sub = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_ready", 32'(in_ready), 32'd0);
            check("stall_s", 32'(s), 32'(e[7:0]));
            check("stall_co", 32'(co), 32'(e[8]));
        end
        out_ready = 1'b1;
        tick();
        check("release_ready", 32'(in_ready), 32'd1);
        check("release_valid", 32'(out_valid), 32'd0);
        check("held_s", 32'(s), 32'(e[7:0]));
        applyStimulus(8'hA5, 8'h11, 1'b0, 1'b1);
        checkOutput("after_stall", 8'hA5, 8'h11, 1'b0, 1'b1);
        finishOp();

        // Reset during the second ADD cycle
        a = 8'h33; b = 8'h44; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_co", 32'(co), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
        check("post_rst_s", 32'(s), 32'h30);
        finishOp();

        // Back-to-back operations with in_valid held high
        bx = 8'($urandom); by = 8'($urandom);
        bc = 1'($urandom_range(0, 1)); bs = 1'($urandom_range(0, 1));
        a = bx; b = by; ci = bc; sub = bs; in_valid = 1'b1; out_ready = 1'b1;
        nAcc = 0; nRes = 0;
        for (int c = 0; c < 80 && nRes < 3; c++) begin
            acceptNow = in_ready && in_valid && (nAcc < 3);
            if (acceptNow) begin
                expQ.push_back(refModel(bx, by, bc, bs));
                accT.push_back(c);
                nAcc++;
            end
            if (out_valid) begin
                check("b2b_ready_low", 32'(in_ready), 32'd0);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    check("b2b_s", 32'(s), 32'(e[7:0]));
                    check("b2b_co", 32'(co), 32'(e[8]));
                end else begin
                    check("b2b_unexpected_result", 32'd1, 32'd0);
                end
                nRes++;
            end
            tick();
            if (acceptNow) begin
                if (nAcc == 3) begin
                    in_valid = 1'b0;
                end else begin
                    bx = 8'($urandom); by = 8'($urandom);
                    bc = 1'($urandom_range(0, 1)); bs = 1'($urandom_range(0, 1));
                    a = bx; b = by; ci = bc; sub = bs;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_results", 32'(nRes), 32'd3);
        check("b2b_accepts", 32'(accT.size()), 32'd3);
        if (accT.size() == 3) begin
            check("b2b_spacing1", 32'(accT[1] - accT[0]), 32'(NCHUNK + 2));
            check("b2b_spacing2", 32'(accT[2] - accT[1]), 32'(NCHUNK + 2));
        end
        for (int w = 0; w < 16 && !in_ready; w++) tick();

`ifdef SEQ_CHUNK_ADDER_OVF_EN
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
        check("ovf_pos_s", 32'(s), 32'h80);
        check("ovf_pos", 32'(ovf), 32'd1);
        finishOp();
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
        check("ovf_neg_s", 32'(s), 32'h7F);
        check("ovf_neg", 32'(ovf), 32'd1);
        finishOp();
        applyStimulus(8'h10, 8'h10, 1'b0, 1'b0);
        check("ovf_none", 32'(ovf), 32'd0);
        finishOp();
`endif

        for (int n = 0; n < 20; n++) begin
            bx = 8'($urandom); by = 8'($urandom);
            bc = 1'($urandom_range(0, 1)); bs = 1'($urandom_range(0, 1));
            applyStimulus(bx, by, bc, bs);
            checkOutput("rand", bx, by, bc, bs);
            finishOp();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
